// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_unit
//  Purpose  : Instruction-fetch stage. Owns the PC, drives a req/ack
//             instruction-memory port with variable latency, buffers the
//             returned words in a small prefetch FIFO and loads the IF/ID
//             register seen by the decoder.
//  Revision : 1.0  initial release
// ============================================================================
module if_fetch_unit #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_inst,
  output logic [ADDR_W-1:0] id_pc_plus4
);

  localparam int                PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int                CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] FOUR_C  = ADDR_W'(4);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,   // no request outstanding
    S_BUSY  = 2'd1,   // request outstanding, its data will be kept
    S_DRAIN = 2'd2    // request outstanding, its data is stale
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic               req_q, req_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;

  // Prefetch FIFO: each entry is {fetch address + 4, instruction}
  logic [ADDR_W-1:0]  fifo_pc_q   [FIFO_DEPTH];
  logic [DATA_W-1:0]  fifo_inst_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               id_valid_q;
  logic [DATA_W-1:0]  id_inst_q;
  logic [ADDR_W-1:0]  id_pc_plus4_q;

  logic               w_push;
  logic               w_pop;
  logic               w_space;
  logic [ADDR_W-1:0]  w_drain_pc;

  // FIFO occupancy after this cycle's push/pop/flush, and whether a new
  // request can be issued against it
  always_comb begin
    w_pop   = !flush && !stall && (count_q != '0);
    w_push  = (state_q == S_BUSY) && imem_ack && !flush;
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (w_push && !w_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      count_d = count_q - CNT_W'(1);
    end
    w_space = (count_d < DEPTH_C);
  end

  // Fetch FSM next-state: request issue, hold-until-ack, redirect handling
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_d      = req_q;
    addr_d     = addr_q;
    w_drain_pc = flush ? redirect_pc : fetch_pc_q;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          // Redirect only; the request goes out on the following cycle
          fetch_pc_d = redirect_pc;
        end else if (count_q < DEPTH_C) begin
          state_d = S_BUSY;
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
        end
      end
      S_BUSY: begin
        if (imem_ack) begin
          if (flush) begin
            // Response is stale; go straight to the redirect target
            fetch_pc_d = redirect_pc;
            state_d    = S_BUSY;
            req_d      = 1'b1;
            addr_d     = redirect_pc;
          end else begin
            fetch_pc_d = fetch_pc_q + FOUR_C;
            if (w_space) begin
              state_d = S_BUSY;
              req_d   = 1'b1;
              addr_d  = fetch_pc_q + FOUR_C;
            end else begin
              state_d = S_IDLE;
              req_d   = 1'b0;
            end
          end
        end else if (flush) begin
          // Requests are never aborted: wait for the ack and drop it
          state_d    = S_DRAIN;
          fetch_pc_d = redirect_pc;
        end
      end
      S_DRAIN: begin
        fetch_pc_d = w_drain_pc;
        if (imem_ack) begin
          if (w_space) begin
            state_d = S_BUSY;
            req_d   = 1'b1;
            addr_d  = w_drain_pc;
          end else begin
            state_d = S_IDLE;
            req_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // Fetch FSM state, PC and memory-port registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
    end
  end

  // FIFO pointers and occupancy; flush empties the buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count
  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_pc_q[wr_ptr_q]   <= addr_q + FOUR_C;
      fifo_inst_q[wr_ptr_q] <= imem_rdata;
    end
  end

  // IF/ID register: flush beats stall, stall holds, otherwise pop or bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_valid_q    <= 1'b0;
      id_inst_q     <= '0;
      id_pc_plus4_q <= '0;
    end else if (flush) begin
      id_valid_q <= 1'b0;
      id_inst_q  <= '0;
    end else if (!stall) begin
      if (count_q != '0) begin
        id_valid_q    <= 1'b1;
        id_inst_q     <= fifo_inst_q[rd_ptr_q];
        id_pc_plus4_q <= fifo_pc_q[rd_ptr_q];
      end else begin
        id_valid_q <= 1'b0;
        id_inst_q  <= '0;
      end
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign id_valid    = id_valid_q;
  assign id_inst     = id_inst_q;
  assign id_pc_plus4 = id_pc_plus4_q;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_fetch_unit
//  Purpose  : Directed self-checking bench for if_fetch_unit with a
//             latency-programmable instruction memory responder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] redirect_pc;
  wire         imem_req;
  wire  [31:0] imem_addr;
  wire         imem_ack;
  wire  [31:0] imem_rdata;
  wire         id_valid;
  wire  [31:0] id_inst;
  wire  [31:0] id_pc_plus4;

  logic        mdl_ack   = 1'b0;
  logic [31:0] mdl_rdata = 32'h0;
  logic        frc_ack;
  int          lat;
  int          wcnt      = 0;

  int n_cmp = 0;
  int n_bad = 0;

  assign imem_ack   = mdl_ack | frc_ack;
  assign imem_rdata = mdl_rdata;

  if_fetch_unit #(
    .ADDR_W    (32),
    .DATA_W    (32),
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .flush      (flush),
    .redirect_pc(redirect_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .id_valid   (id_valid),
    .id_inst    (id_inst),
    .id_pc_plus4(id_pc_plus4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 | {16'h0000, a[15:0]};
  endfunction

  // Memory responder: acks a request after 'lat' cycles, data valid in ack cycle
  always @(negedge clk) begin
    if (imem_req) begin
      if (wcnt + 1 >= lat) begin
        mdl_ack   = 1'b1;
        mdl_rdata = mem_word(imem_addr);
        wcnt      = 0;
      end else begin
        mdl_ack = 1'b0;
        wcnt    = wcnt + 1;
      end
    end else begin
      mdl_ack = 1'b0;
      wcnt    = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_pc = 32'h0;
    lat = 1; frc_ack = 1'b0;
    tick(); tick();
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 00000000", imem_addr); end
    n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", id_valid); end
    n_cmp++; if (id_inst !== 32'h0) begin n_bad++; $display("FAIL reset_inst: got %h want 00000000", id_inst); end
    n_cmp++; if (id_pc_plus4 !== 32'h0) begin n_bad++; $display("FAIL reset_pc4: got %h want 00000000", id_pc_plus4); end
  endtask

  task automatic test_stream();
    rst = 1'b0;
    tick();  // E1: first request to 0
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_bad++; $display("FAIL stream_e1_req: got %b/%h want 1/00000000", imem_req, imem_addr); end
    n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL stream_e1_valid: got %b want 0", id_valid); end
    tick();  // E2: acked, next request to 4
    n_cmp++; if (imem_addr !== 32'h4) begin n_bad++; $display("FAIL stream_e2_addr: got %h want 00000004", imem_addr); end
    n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL stream_e2_valid: got %b want 0", id_valid); end
    for (int k = 1; k <= 2; k++) begin  // E3, E4: one instruction per cycle
      tick();
      n_cmp++;
      if (id_valid !== 1'b1 || id_pc_plus4 !== 32'(4 * k) || id_inst !== mem_word(32'(4 * (k - 1)))) begin
        n_bad++;
        $display("FAIL stream_id_%0d: got %b/%h/%h want 1/%h/%h", k, id_valid, id_pc_plus4, id_inst, 32'(4 * k), mem_word(32'(4 * (k - 1))));
      end
      n_cmp++; if (imem_addr !== 32'(4 * (k + 1))) begin n_bad++; $display("FAIL stream_addr_%0d: got %h want %h", k, imem_addr, 32'(4 * (k + 1))); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin  // E5, E6
      tick();
      n_cmp++;
      if (id_valid !== 1'b1 || id_pc_plus4 !== 32'h8 || id_inst !== mem_word(32'h4)) begin
        n_bad++;
        $display("FAIL stall_hold_%0d: got %b/%h/%h want 1/00000008/%h", k, id_valid, id_pc_plus4, id_inst, mem_word(32'h4));
      end
      n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL stall_req_%0d: got %b want 0", k, imem_req); end
    end
    stall = 1'b0;
    tick();  // E7
    n_cmp++; if (id_valid !== 1'b1 || id_pc_plus4 !== 32'hC || id_inst !== mem_word(32'h8)) begin n_bad++; $display("FAIL stall_rel_12: got %b/%h/%h want 1/0000000c/%h", id_valid, id_pc_plus4, id_inst, mem_word(32'h8)); end
    tick();  // E8
    n_cmp++; if (id_valid !== 1'b1 || id_pc_plus4 !== 32'h10 || id_inst !== mem_word(32'hC)) begin n_bad++; $display("FAIL stall_rel_16: got %b/%h/%h want 1/00000010/%h", id_valid, id_pc_plus4, id_inst, mem_word(32'hC)); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_bad++; $display("FAIL stall_refetch: got %b/%h want 1/00000010", imem_req, imem_addr); end
  endtask

  task automatic test_flush_inflight();
    lat = 3; flush = 1'b1; redirect_pc = 32'h100;
    tick();  // E9: flush, request to 0x10 still outstanding
    flush = 1'b0;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_bad++; $display("FAIL drain_hold_e9: got %b/%h want 1/00000010", imem_req, imem_addr); end
    n_cmp++; if (id_valid !== 1'b0 || id_inst !== 32'h0) begin n_bad++; $display("FAIL drain_id_e9: got %b/%h want 0/00000000", id_valid, id_inst); end
    tick();  // E10
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin n_bad++; $display("FAIL drain_hold_e10: got %b/%h want 1/00000010", imem_req, imem_addr); end
    tick();  // E11: stale ack consumed, redirect target requested
    lat = 1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_bad++; $display("FAIL drain_redirect: got %b/%h want 1/00000100", imem_req, imem_addr); end
    n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL drain_id_e11: got %b want 0", id_valid); end
    tick();  // E12: stale data must not have been pushed
    n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL drain_stale: got %b/%h want 0", id_valid, id_inst); end
    tick();  // E13
    n_cmp++; if (id_valid !== 1'b1 || id_pc_plus4 !== 32'h104 || id_inst !== mem_word(32'h100)) begin n_bad++; $display("FAIL drain_target: got %b/%h/%h want 1/00000104/%h", id_valid, id_pc_plus4, id_inst, mem_word(32'h100)); end
  endtask

  task automatic test_flush_stall_ack();
    flush = 1'b1; stall = 1'b1; redirect_pc = 32'h200;
    tick();  // E14: flush + stall + ack together
    flush = 1'b0; stall = 1'b0;
    n_cmp++; if (id_valid !== 1'b0 || id_inst !== 32'h0) begin n_bad++; $display("FAIL fsa_id: got %b/%h want 0/00000000", id_valid, id_inst); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_bad++; $display("FAIL fsa_addr: got %b/%h want 1/00000200", imem_req, imem_addr); end
    tick();  // E15
    n_cmp++; if (id_valid !== 1'b0) begin n_bad++; $display("FAIL fsa_stale: got %b/%h want 0", id_valid, id_inst); end
    tick();  // E16
    n_cmp++; if (id_valid !== 1'b1 || id_pc_plus4 !== 32'h204 || id_inst !== mem_word(32'h200)) begin n_bad++; $display("FAIL fsa_target: got %b/%h/%h want 1/00000204/%h", id_valid, id_pc_plus4, id_inst, mem_word(32'h200)); end
  endtask

  task automatic test_wrap();
    flush = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();  // E17
    flush = 1'b0;
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_issue: got %h want fffffffc", imem_addr); end
    tick();  // E18
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL wrap_next_addr: got %h want 00000000", imem_addr); end
    tick();  // E19
    n_cmp++; if (id_valid !== 1'b1 || id_pc_plus4 !== 32'h0 || id_inst !== mem_word(32'hFFFF_FFFC)) begin n_bad++; $display("FAIL wrap_id: got %b/%h/%h want 1/00000000/%h", id_valid, id_pc_plus4, id_inst, mem_word(32'hFFFF_FFFC)); end
  endtask

  task automatic test_reset_mid();
    lat = 100;
    tick();  // E20: request to 4 outstanding, never acked by the model
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL rmid_busy: got %b want 1", imem_req); end
    rst = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin n_bad++; $display("FAIL rmid_async: got %b/%h want 0/00000000", imem_req, imem_addr); end
    n_cmp++; if (id_valid !== 1'b0 || id_pc_plus4 !== 32'h0) begin n_bad++; $display("FAIL rmid_id: got %b/%h want 0/00000000", id_valid, id_pc_plus4); end
    tick();  // E21 in reset
    rst = 1'b0; frc_ack = 1'b1;
    tick();  // E22: late ack while idle must be ignored
    frc_ack = 1'b0; lat = 1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_bad++; $display("FAIL rmid_restart: got %b/%h want 1/00000000", imem_req, imem_addr); end
    tick();  // E23
    n_cmp++; if (id_valid !== 1'b0 || imem_addr !== 32'h4) begin n_bad++; $display("FAIL rmid_nopush: got %b/%h want 0/00000004", id_valid, imem_addr); end
    tick();  // E24
    n_cmp++; if (id_valid !== 1'b1 || id_pc_plus4 !== 32'h4 || id_inst !== mem_word(32'h0)) begin n_bad++; $display("FAIL rmid_first: got %b/%h/%h want 1/00000004/%h", id_valid, id_pc_plus4, id_inst, mem_word(32'h0)); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush_inflight();
    test_flush_stall_ack();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
